booth_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one iterative signed Booth multiplier core among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues a one-cycle start pulse to the core. It waits for the core's done pulse, with a watchdog, and returns the product tagged with the requester ID over a valid/ready response channel. It sits between the requesting datapath blocks and the single shared multiplier core.

---
 rtl/booth_mul_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin front end that shares one iterative signed
// Booth multiplier core among NUM_REQ requesters.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                requester that owns the response
//   rsp_product, rsp_err  product (zero on timeout) and timeout flag
//   mul_start, mul_a/b    one-cycle start pulse and held operands to the core
//   mul_done, mul_product core completion pulse and its product
//   busy                  transaction in flight
//   timeout_err           sticky watchdog flag, cleared only by reset
module booth_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IdW-1:0]           rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     rsp_err,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     busy,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e         state;
  logic [IdW-1:0] rr_ptr;
  logic [7:0]     wd_cnt;
  logic [7:0]     wd_next;
  logic           grant_found;
  logic [IdW-1:0] grant_idx;

  assign wd_next = wd_cnt + 8'd1;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IdW-1:0];
      end
    end
  end

  // Gated by reset so the handshake is silent while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == StIdle && grant_found && !reset) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (grant_found) begin
            mul_a     <= req_a[32'(grant_idx)*WIDTH +: WIDTH];
            mul_b     <= req_b[32'(grant_idx)*WIDTH +: WIDTH];
            rsp_id    <= grant_idx;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= StIssue;
          end
        end
        StIssue: begin
          mul_start <= 1'b0;
          wd_cnt    <= '0;
          state     <= StWait;
        end
        StWait: begin
          // A done arriving on the final watchdog cycle still wins.
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= StResp;
          end else if (wd_next == 8'(TIMEOUT)) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            timeout_err <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= StResp;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= (32'(rsp_id) == NUM_REQ - 1) ? '0 : rsp_id + 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
